// File: rtl/life_pkg.sv
// Shared definitions for the Life board memory subsystem.
// Board geometry, address width and read-source encoding.
package life_pkg;
    localparam int LOG_W  = 6;
    localparam int LOG_H  = 5;
    localparam int ADDR_W = LOG_W + LOG_H;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_DISP,
        SRC_ENG,
        SRC_WR
    } src_e;
endpackage

// File: rtl/life_mem_arbiter_if.sv
// Requester and RAM signals of the Life board memory arbiter.
// master: requesters plus RAM; slave: the arbiter.
interface life_mem_arbiter_if
    import life_pkg::*;
#(
    parameter int AW = ADDR_W
);
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_gnt;
    logic          disp_rvalid;
    logic          disp_rdata;
    logic          eng_req;
    logic [AW-1:0] eng_addr;
    logic          eng_gnt;
    logic          eng_rvalid;
    logic          eng_rdata;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic          wr_data;
    logic          wr_gnt;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic          mem_wdata;
    logic          mem_rdata;
    logic          starve_evt;

    modport master (
        output disp_req, disp_addr, eng_req, eng_addr,
        output wr_req, wr_addr, wr_data, mem_rdata,
        input  disp_gnt, disp_rvalid, disp_rdata,
        input  eng_gnt, eng_rvalid, eng_rdata, wr_gnt,
        input  mem_en, mem_we, mem_addr, mem_wdata, starve_evt
    );

    modport slave (
        input  disp_req, disp_addr, eng_req, eng_addr,
        input  wr_req, wr_addr, wr_data, mem_rdata,
        output disp_gnt, disp_rvalid, disp_rdata,
        output eng_gnt, eng_rvalid, eng_rdata, wr_gnt,
        output mem_en, mem_we, mem_addr, mem_wdata, starve_evt
    );
endinterface

// File: rtl/rr2_arbiter.sv
// Two-way round-robin arbiter; the pointer moves to the
// loser after every grant so both sides alternate under load.
module rr2_arbiter (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt0  = 1'b0;
        gnt1  = 1'b0;
        ptr_d = ptr_q;
        if (en) begin
            if (req0 && (!req1 || !ptr_q)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
        if (gnt0) ptr_d = 1'b1;
        if (gnt1) ptr_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= 1'b0;
        else        ptr_q <= ptr_d;
    end
endmodule

// File: rtl/life_mem_arbiter.sv
// Board RAM arbiter: display first, eng/wr round-robin,
// with a starvation guard that steals one display slot.
module life_mem_arbiter
    import life_pkg::*;
#(
    parameter int STARVE_LIMIT = 64,
    parameter int CNT_W        = 7
) (
    input logic               clk,
    input logic               rst_n,
    life_mem_arbiter_if.slave bus
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic             force_q;
    logic             force_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    src_e             src_q;
    src_e             src_d;
    logic             rr_any;
    logic             preempt;
    logic             rr_en;
    logic             disp_g;
    logic             eng_g;
    logic             wr_g;

    assign rr_any  = bus.eng_req | bus.wr_req;
    // A forced slot only steals from display when eng/wr still want it
    assign preempt = force_q & rr_any;
    assign rr_en   = rst_n & (preempt | ~bus.disp_req);
    assign disp_g  = rst_n & bus.disp_req & ~preempt;

    rr2_arbiter u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (rr_en),
        .req0  (bus.eng_req),
        .req1  (bus.wr_req),
        .gnt0  (eng_g),
        .gnt1  (wr_g)
    );

    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = 1'b0;
        src_d         = SRC_NONE;
        unique case (1'b1)
            disp_g: begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = bus.disp_addr;
                src_d        = SRC_DISP;
            end
            eng_g: begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = bus.eng_addr;
                src_d        = SRC_ENG;
            end
            wr_g: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = bus.wr_addr;
                bus.mem_wdata = bus.wr_data;
                src_d         = SRC_WR;
            end
            default: ;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (force_q || eng_g || wr_g) begin
            cnt_d = '0;
        end else if (rr_any && cnt_q != LIMIT) begin
            cnt_d = cnt_q + 1'b1;
        end
        force_d = (cnt_d == LIMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            force_q <= 1'b0;
            cnt_q   <= '0;
            src_q   <= SRC_NONE;
        end else begin
            force_q <= force_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
        end
    end

    assign bus.disp_gnt    = disp_g;
    assign bus.eng_gnt     = eng_g;
    assign bus.wr_gnt      = wr_g;
    assign bus.starve_evt  = rst_n & preempt;
    assign bus.disp_rvalid = (src_q == SRC_DISP);
    assign bus.eng_rvalid  = (src_q == SRC_ENG);
    assign bus.disp_rdata  = bus.disp_rvalid & bus.mem_rdata;
    assign bus.eng_rdata   = bus.eng_rvalid & bus.mem_rdata;
endmodule
